bcd_display_sched: RTL and testbench

- Sequences the shared binary-to-BCD converter for the auto-scaled frequency counter.
- Accepts 20-bit measurement results, issues conversions using the converter's start/ready/done_tick handshake, and captures the 11 BCD digits.
- Selects a 4-digit display window auto-scaled on the most significant non-zero digit, and publishes that window, an exponent and a leading-zero blank mask to the 7-segment driver.
- Holds one pending measurement while a conversion is in flight.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_display_sched_if.sv | 34 +++
 rtl/bcd_autorange.sv | 67 ++++++
 rtl/bcd_display_sched.sv | 136 +++++++++++++
 tb/tb_bcd_display_sched.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display scheduler: controller states,
// digit geometry and a digit-extraction helper.
package bcd_pkg;

    localparam int NDIG  = 11;  // digits delivered by the converter
    localparam int WIN   = 4;   // digits shown on the display
    localparam int DIG_W = 4;   // bits per BCD digit

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        SCALE     = 3'd3,
        PUBLISH   = 3'd4
    } state_e;

    // Return BCD digit idx (0 = least significant) of a packed digit vector.
    function automatic logic [DIG_W-1:0] get_digit(
        input logic [NDIG*DIG_W-1:0] digits,
        input int                    idx
    );
        return digits[idx*DIG_W +: DIG_W];
    endfunction

endpackage

// File: rtl/bcd_display_sched_if.sv
// Bundle of the measurement input, converter handshake and display outputs.
// master = the scheduler, slave = its environment (counter, converter, driver).
interface bcd_display_sched_if #(
    parameter int W = 20
) ();

    logic          meas_valid;
    logic [W-1:0]  meas_value;
    logic          conv_ready;
    logic          conv_done;
    logic [43:0]   conv_digits;
    logic          conv_start;
    logic [W-1:0]  conv_bin;
    logic [15:0]   disp_digits;
    logic [1:0]    disp_exp;
    logic [3:0]    disp_blank;
    logic          disp_valid;
    logic          overrun;
    logic          conv_err;
    logic          busy;

    modport master (
        input  meas_valid, meas_value, conv_ready, conv_done, conv_digits,
        output conv_start, conv_bin, disp_digits, disp_exp, disp_blank,
               disp_valid, overrun, conv_err, busy
    );

    modport slave (
        output meas_valid, meas_value, conv_ready, conv_done, conv_digits,
        input  conv_start, conv_bin, disp_digits, disp_exp, disp_blank,
               disp_valid, overrun, conv_err, busy
    );

endinterface

// File: rtl/bcd_autorange.sv
// Combinational auto-ranging: finds the most significant non-zero digit,
// picks a 4-digit window (truncating, never rounding) and builds the
// leading-zero blank mask for unscaled values.
module bcd_autorange
    import bcd_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic [NDIG*DIG_W-1:0] digits,
    output logic [WIN*DIG_W-1:0]  window,
    output logic [1:0]            exp_s,
    output logic [WIN-1:0]        blank
);

    logic [3:0] m_s;
    logic [3:0] s_wide_s;

    // Index of the highest non-zero digit; later (higher) hits overwrite earlier ones.
    always_comb begin
        m_s = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (get_digit(digits, i) != 4'd0) begin
                m_s = 4'(i);
            end else begin
                m_s = m_s;
            end
        end
    end

    // Shift amount: keep the top digit in window position 3, saturating at 3.
    always_comb begin
        s_wide_s = 4'd0;
        exp_s    = 2'd0;
        if (m_s > 4'd3) begin
            s_wide_s = m_s - 4'd3;
        end else begin
            s_wide_s = 4'd0;
        end
        if (s_wide_s > 4'd3) begin
            exp_s = 2'd3;
        end else begin
            exp_s = s_wide_s[1:0];
        end
    end

    // Window selection and leading-zero blanking (only when unscaled).
    always_comb begin
        window = 16'h0000;
        blank  = 4'b0000;
        case (exp_s)
            2'd0:    window = digits[15:0];
            2'd1:    window = digits[19:4];
            2'd2:    window = digits[23:8];
            2'd3:    window = digits[27:12];
            default: window = 16'h0000;
        endcase
        if (BLANK_LZ && (exp_s == 2'd0)) begin
            blank[3] = (window[15:12] == 4'd0);
            blank[2] = blank[3] && (window[11:8] == 4'd0);
            blank[1] = blank[2] && (window[7:4] == 4'd0);
            blank[0] = 1'b0;
        end else begin
            blank = 4'b0000;
        end
    end

endmodule

// File: rtl/bcd_display_sched.sv
// Scheduler for the shared binary-to-BCD converter: accepts measurements,
// runs one conversion at a time with a one-entry pending buffer, and
// publishes an auto-scaled 4-digit window to the display driver.
module bcd_display_sched
    import bcd_pkg::*;
#(
    parameter int W        = 20,
    parameter int TIMEOUT  = 63,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    bcd_display_sched_if.master bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e                  state_r;
    logic [W-1:0]            conv_bin_r;
    logic [W-1:0]            pend_r;
    logic                    pend_full_r;
    logic [TW-1:0]           timer_r;
    logic [NDIG*DIG_W-1:0]   digits_r;
    logic [WIN*DIG_W-1:0]    disp_digits_r;
    logic [1:0]              disp_exp_r;
    logic [WIN-1:0]          disp_blank_r;
    logic                    disp_valid_r;
    logic                    overrun_r;
    logic                    conv_err_r;

    logic [WIN*DIG_W-1:0]    win_s;
    logic [1:0]              exp_s;
    logic [WIN-1:0]          blank_s;

    bcd_autorange #(
        .BLANK_LZ (BLANK_LZ)
    ) u_autorange (
        .digits (digits_r),
        .window (win_s),
        .exp_s  (exp_s),
        .blank  (blank_s)
    );

    // Controller FSM with timeout timer, pending buffer and display registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            conv_bin_r    <= '0;
            pend_r        <= '0;
            pend_full_r   <= 1'b0;
            timer_r       <= '0;
            digits_r      <= '0;
            disp_digits_r <= 16'h0000;
            disp_exp_r    <= 2'd0;
            disp_blank_r  <= 4'b1110;
            disp_valid_r  <= 1'b0;
            overrun_r     <= 1'b0;
            conv_err_r    <= 1'b0;
        end else begin
            disp_valid_r <= 1'b0;

            // A measurement arriving while busy parks in the pending slot;
            // clobbering an unconsumed entry is flagged.
            if (bus.meas_valid && (state_r != IDLE)) begin
                pend_r      <= bus.meas_value;
                pend_full_r <= 1'b1;
                if (pend_full_r) begin
                    overrun_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    if (bus.meas_valid) begin
                        // Fresh data beats stale pending data.
                        conv_bin_r <= bus.meas_value;
                        state_r    <= ISSUE;
                        if (pend_full_r) begin
                            pend_full_r <= 1'b0;
                            overrun_r   <= 1'b1;
                        end
                    end else if (pend_full_r) begin
                        conv_bin_r  <= pend_r;
                        pend_full_r <= 1'b0;
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (bus.conv_ready) begin
                        timer_r <= '0;
                        state_r <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.conv_done) begin
                        digits_r <= bus.conv_digits;
                        state_r  <= SCALE;
                    end else if (timer_r == TW'(TIMEOUT)) begin
                        conv_err_r <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                SCALE: begin
                    disp_digits_r <= win_s;
                    disp_exp_r    <= exp_s;
                    disp_blank_r  <= blank_s;
                    disp_valid_r  <= 1'b1;
                    state_r       <= PUBLISH;
                end
                PUBLISH: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // The start pulse must coincide with the converter's ready, so it is a
    // decode of the registered state qualified by conv_ready.
    assign bus.conv_start  = (state_r == ISSUE) && bus.conv_ready;
    assign bus.conv_bin    = conv_bin_r;
    assign bus.disp_digits = disp_digits_r;
    assign bus.disp_exp    = disp_exp_r;
    assign bus.disp_blank  = disp_blank_r;
    assign bus.disp_valid  = disp_valid_r;
    assign bus.overrun     = overrun_r;
    assign bus.conv_err    = conv_err_r;
    assign bus.busy        = (state_r != IDLE);

endmodule

// File: tb/tb_bcd_display_sched.sv
// Self-checking bench for bcd_display_sched with a behavioural 22-cycle
// binary-to-BCD converter and an arithmetic reference for the display window.
module tb_bcd_display_sched;

    localparam int W        = 20;
    localparam int TIMEOUT  = 63;
    localparam int CONV_LAT = 22;
    localparam bit BLANK_LZ = 1'b1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bcd_display_sched_if #(.W(W)) bus ();

    bcd_display_sched #(
        .W        (W),
        .TIMEOUT  (TIMEOUT),
        .BLANK_LZ (BLANK_LZ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Measurement stimulus
    logic         mv   = 1'b0;
    logic [W-1:0] mval = '0;
    assign bus.meas_valid = mv;
    assign bus.meas_value = mval;

    // Converter model state (never reset by the controller)
    logic        cv_ready   = 1'b1;
    logic        cv_done    = 1'b0;
    logic [43:0] cv_digits  = '0;
    logic        cv_done_en = 1'b1;
    int          cv_cnt     = 0;
    int unsigned cv_val     = 0;
    assign bus.conv_ready  = cv_ready;
    assign bus.conv_done   = cv_done;
    assign bus.conv_digits = cv_digits;

    function automatic logic [43:0] to_bcd(input int unsigned v);
        logic [43:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < 11; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Converter: start accepted when ready, done_tick 21 cycles later,
    // ready again the cycle after done.
    always @(posedge clk) begin
        cv_done <= 1'b0;
        if (cv_ready && bus.conv_start) begin
            cv_ready <= 1'b0;
            cv_val   <= {12'd0, bus.conv_bin};
            cv_cnt   <= CONV_LAT - 2;
        end else if (!cv_ready) begin
            if (cv_cnt > 1) begin
                cv_cnt <= cv_cnt - 1;
            end else if (cv_cnt == 1) begin
                cv_cnt    <= 0;
                cv_done   <= cv_done_en;
                cv_digits <= to_bcd(cv_val);
            end else begin
                cv_ready <= 1'b1;
            end
        end
    end

    // Reference display: divide by the power of ten that keeps the most
    // significant digit in the top window position.
    function automatic void ref_disp(input int unsigned v, output logic [15:0] dg,
                                     output logic [1:0] ex, output logic [3:0] bl);
        int unsigned t;
        int unsigned p;
        int unsigned win;
        int m;
        int s;
        t = v;
        m = 0;
        for (int i = 0; i < 11; i++) begin
            if (t % 10 != 0) m = i;
            t = t / 10;
        end
        s = (m > 3) ? m - 3 : 0;
        if (s > 3) s = 3;
        p = 1;
        for (int i = 0; i < s; i++) p = p * 10;
        win = (v / p) % 10000;
        dg = {4'(win / 1000), 4'((win / 100) % 10), 4'((win / 10) % 10), 4'(win % 10)};
        ex = 2'(s);
        if (BLANK_LZ && s == 0) bl = {win < 1000, win < 100, win < 10, 1'b0};
        else                    bl = 4'b0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},    32'(bus.busy),        32'd0);
        check({tag, "_start"},   32'(bus.conv_start),  32'd0);
        check({tag, "_bin"},     32'(bus.conv_bin),    32'd0);
        check({tag, "_digits"},  32'(bus.disp_digits), 32'h0);
        check({tag, "_exp"},     32'(bus.disp_exp),    32'd0);
        check({tag, "_blank"},   32'(bus.disp_blank),  32'b1110);
        check({tag, "_valid"},   32'(bus.disp_valid),  32'd0);
        check({tag, "_overrun"}, 32'(bus.overrun),     32'd0);
        check({tag, "_err"},     32'(bus.conv_err),    32'd0);
    endtask

    // Strobe v in cycle 0 (caller sits at a negedge) and report the cycles
    // of the first conv_start and of disp_valid (-1 if not seen).
    task automatic run_conv(input int unsigned v, output int start_cyc, output int valid_cyc);
        start_cyc = -1;
        valid_cyc = -1;
        mv   = 1'b1;
        mval = W'(v);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            mv = 1'b0;
            if (bus.conv_start && start_cyc < 0) start_cyc = c;
            if (bus.disp_valid) begin
                valid_cyc = c;
                break;
            end
        end
    endtask

    typedef struct {
        int unsigned val;
        logic [15:0] dg;
        logic [1:0]  ex;
        logic [3:0]  bl;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int s_cyc;
        int v_cyc;
        int unsigned v;
        logic [15:0] e_dg;
        logic [1:0]  e_ex;
        logic [3:0]  e_bl;
        int ndisp;
        int err_cyc;
        logic busy_at_err;
        int bad_start;

        vecs[0] = '{1234,    16'h1234, 2'd0, 4'b0000};
        vecs[1] = '{56,      16'h0056, 2'd0, 4'b1100};
        vecs[2] = '{0,       16'h0000, 2'd0, 4'b1110};
        vecs[3] = '{1048575, 16'h1048, 2'd3, 4'b0000};
        vecs[4] = '{12345,   16'h1234, 2'd1, 4'b0000};
        vecs[5] = '{999,     16'h0999, 2'd0, 4'b1000};
        vecs[6] = '{10000,   16'h1000, 2'd1, 4'b0000};
        vecs[7] = '{9,       16'h0009, 2'd0, 4'b1110};

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].val, s_cyc, v_cyc);
            check($sformatf("tbl%0d_start_lat", i), 32'(s_cyc), 32'd1);
            check($sformatf("tbl%0d_valid_lat", i), 32'(v_cyc), 32'd24);
            check($sformatf("tbl%0d_digits", i), 32'(bus.disp_digits), 32'(vecs[i].dg));
            check($sformatf("tbl%0d_exp", i),    32'(bus.disp_exp),    32'(vecs[i].ex));
            check($sformatf("tbl%0d_blank", i),  32'(bus.disp_blank),  32'(vecs[i].bl));
            @(negedge clk);
            check($sformatf("tbl%0d_pulse", i), 32'(bus.disp_valid), 32'd0);
            repeat (2) @(negedge clk);
        end
        check("no_overrun", 32'(bus.overrun),  32'd0);
        check("no_err",     32'(bus.conv_err), 32'd0);

        // Random magnitudes against the reference
        for (int i = 0; i < 30; i++) begin
            v = $urandom_range(0, 1048575) >> $urandom_range(0, 19);
            ref_disp(v, e_dg, e_ex, e_bl);
            run_conv(v, s_cyc, v_cyc);
            check($sformatf("rnd%0d_valid_lat", i), 32'(v_cyc), 32'd24);
            check($sformatf("rnd%0d_digits(%0d)", i, v), 32'(bus.disp_digits), 32'(e_dg));
            check($sformatf("rnd%0d_exp(%0d)", i, v),    32'(bus.disp_exp),    32'(e_ex));
            check($sformatf("rnd%0d_blank(%0d)", i, v),  32'(bus.disp_blank),  32'(e_bl));
            repeat (3) @(negedge clk);
        end

        // Overrun: 100 @0, 200 @5, 300 @6
        ndisp = 0;
        mv = 1'b1;
        mval = W'(100);
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 5)      begin mv = 1'b1; mval = W'(200); end
            else if (c == 6) begin mv = 1'b1; mval = W'(300); end
            else             mv = 1'b0;
            if (bus.disp_valid) begin
                ndisp++;
                if (ndisp == 1) begin
                    ref_disp(100, e_dg, e_ex, e_bl);
                    check("ovr_first_digits", 32'(bus.disp_digits), 32'(e_dg));
                    check("ovr_flag",         32'(bus.overrun),     32'd1);
                end else begin
                    ref_disp(300, e_dg, e_ex, e_bl);
                    check("ovr_second_digits", 32'(bus.disp_digits), 32'(e_dg));
                end
            end
        end
        check("ovr_display_count", 32'(ndisp), 32'd2);

        // Timeout: converter never signals done
        cv_done_en  = 1'b0;
        ndisp       = 0;
        err_cyc     = -1;
        busy_at_err = 1'b1;
        mv = 1'b1;
        mval = W'(4321);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            mv = 1'b0;
            if (bus.disp_valid) ndisp++;
            if (bus.conv_err && err_cyc < 0) begin
                err_cyc = c;
                busy_at_err = bus.busy;
            end
        end
        ref_disp(300, e_dg, e_ex, e_bl);
        check("tmo_err_cycle",  32'(err_cyc),        32'd66);
        check("tmo_busy_drop",  32'(busy_at_err),    32'd0);
        check("tmo_no_valid",   32'(ndisp),          32'd0);
        check("tmo_digits_kept", 32'(bus.disp_digits), 32'(e_dg));
        check("tmo_blank_kept",  32'(bus.disp_blank),  32'(e_bl));
        cv_done_en = 1'b1;
        repeat (5) @(negedge clk);

        // Reset in the middle of a conversion
        mv = 1'b1;
        mval = W'(5555);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            mv = 1'b0;
        end
        check("mid_in_wait_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_conv_still_busy", 32'(cv_ready), 32'd0);
        bad_start = 0;
        s_cyc = -1;
        v_cyc = -1;
        mv = 1'b1;
        mval = W'(77);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            mv = 1'b0;
            if (bus.conv_start && !cv_ready) bad_start++;
            if (bus.conv_start && s_cyc < 0) s_cyc = c;
            if (bus.disp_valid) begin
                v_cyc = c;
                break;
            end
        end
        ref_disp(77, e_dg, e_ex, e_bl);
        check("mid_start_while_busy", 32'(bad_start), 32'd0);
        check("mid_start_delayed",    32'(s_cyc > 1), 32'd1);
        check("mid_start_to_valid",   32'(v_cyc - s_cyc), 32'd23);
        check("mid_digits",           32'(bus.disp_digits), 32'(e_dg));
        check("mid_blank",            32'(bus.disp_blank),  32'(e_bl));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
